tc_scan_ctrl: RTL and testbench
===============================

TC_SCAN_CTRL -- requirements
Module: tc_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_TC, default 16: number of timer/counter channels.
REQ-002 SHALL have parameter PRESET_LEN, default 8: preset and accumulator width in bits.
REQ-003 SHALL have parameter ADDR_LEN, default 4: channel address width, with 2**ADDR_LEN >= NUM_TC.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port tick, input, 1: time-base pulse that requests one scan of all channels.
REQ-007 SHALL have port tcEnable, input, NUM_TC: per-channel run/enable bits from the IL program.
REQ-008 SHALL have port presetFlat, input, PRESET_LEN*NUM_TC: preset bank contents, with channel k at bits [PRESET_LEN*(k+1)-1 : PRESET_LEN*k].
REQ-009 SHALL have port cpuWrEn, input, 1: CPU preset-write strobe.
REQ-010 SHALL have port cpuWrAddr, input, ADDR_LEN: CPU preset-write channel.
REQ-011 SHALL have port cpuWrData, input, PRESET_LEN: CPU preset-write value.
REQ-012 SHALL have port tcPresetEn, output, 1: preset bank write enable.
REQ-013 SHALL have port tcAddr, output, ADDR_LEN: preset bank write address.
REQ-014 SHALL have port presetIn, output, PRESET_LEN: preset bank write data.
REQ-015 SHALL have port tcDone, output, NUM_TC: per-channel done bits.
REQ-016 SHALL have port busy, output, 1: high while the FSM is in SCAN.
REQ-017 SHALL have port scanDone, output, 1: one-cycle pulse when a scan completes.
REQ-018 SHALL have port overrun, output, 1: one-cycle pulse when a tick is lost.

Function
REQ-019 SHALL hold NUM_TC internal accumulators acc[k], each PRESET_LEN bits, and a scan index idx of ADDR_LEN bits.
REQ-020 SHALL implement an FSM with states IDLE and SCAN; busy = (state == SCAN).
REQ-021 IDLE with tick=1 SHALL go to SCAN next cycle with idx=0.
REQ-022 SCAN SHALL process exactly channel idx each cycle, then idx+1; a full scan takes NUM_TC cycles.
REQ-023 Channel processing, p = preset of channel idx, with tcEnable[idx]=0: acc<=0 and tcDone[idx]<=0.
REQ-024 Channel processing with tcEnable[idx]=1 and acc>=p: acc holds and tcDone[idx]<=1; preset 0 therefore sets done on the first enabled scan.
REQ-025 Channel processing with tcEnable[idx]=1 and acc<p: acc<=acc+1, and tcDone[idx]<=1 iff acc+1==p.
REQ-026 acc SHALL never wrap: the increment occurs only when acc<p, so acc<=all-ones.
REQ-027 On the cycle processing idx==NUM_TC-1, scanDone SHALL pulse the next cycle, and the FSM SHALL return to IDLE unless a scan is pending.
REQ-028 A tick during SCAN SHALL set a one-deep pending flag; at scan end with pending set, the FSM SHALL stay in SCAN, restart at idx=0, and clear pending.
REQ-029 A tick during SCAN while pending is already set SHALL be dropped and SHALL pulse overrun for one cycle the next cycle.
REQ-030 A tick on the final scan cycle SHALL count as pending, not lost.
REQ-031 cpuWrEn=1 SHALL register tcPresetEn<=1, tcAddr<=cpuWrAddr, presetIn<=cpuWrData (one-cycle latency); tcPresetEn SHALL otherwise be 0, and tcAddr/presetIn SHALL hold.
REQ-032 cpuWrEn=1 SHALL clear acc[cpuWrAddr] and tcDone[cpuWrAddr] at the same edge.
REQ-033 If cpuWrEn=1 targets the channel being scanned, the clear SHALL win over the scan update.
REQ-034 cpuWrAddr >= NUM_TC SHALL be forwarded to the bank but SHALL NOT alter any internal state.
REQ-035 CPU writes SHALL be accepted in any state without stalling the scan; there is no backpressure.

Reset
REQ-036 When reset=0 at a clock edge, the block SHALL set: state=IDLE, idx=0, pending=0, all acc=0, tcDone=0, busy=0, scanDone=0, overrun=0, tcPresetEn=0, tcAddr=0, presetIn=0.
REQ-037 Reset mid-scan SHALL abort the scan with no scanDone pulse, and SHALL take priority over tick and cpuWrEn in the same cycle.

Verification
REQ-038 Scenario: ch3 preset=3, tcEnable[3]=1, three ticks spaced >16 cycles -> tcDone[3] rises during the 3rd scan at the ch3 slot; a 4th scan leaves acc=3, done=1.
REQ-039 Scenario: single tick from IDLE -> busy high for exactly 16 cycles; scanDone pulses once, one cycle after idx 15.
REQ-040 Scenario: tick at scan cycle 5 and again at cycle 9 -> a second scan starts back-to-back with busy continuous for 32 cycles; overrun pulses once, after the cycle-9 tick.
REQ-041 Scenario: cpuWrEn to ch7 with data 0x20 while the scan is on ch7 and done[7]=1 -> next cycle tcPresetEn=1, tcAddr=7, presetIn=0x20; acc[7]=0, done[7]=0.
REQ-042 Scenario: drop tcEnable[2] with done[2]=1 -> done[2]=0 after the next ch2 slot; preset 0 with enable=1 -> done set on the first scan.
REQ-043 Scenario: reset=0 at scan cycle 8 -> all outputs 0 next cycle; no scanDone pulse; a later tick restarts at idx=0.

Source files
------------

// File: rtl/tc_scan_ctrl.sv
// ============================================================================
// Module      : tc_scan_ctrl
// Description : Timer/counter scan sequencer. Each tick walks every channel
//               once, advancing its accumulator towards its preset, and
//               forwards CPU preset writes to the external preset bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tc_scan_ctrl #(
    parameter int NUM_TC     = 16,
    parameter int PRESET_LEN = 8,
    parameter int ADDR_LEN   = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick,
    input  logic [NUM_TC-1:0]            tcEnable,
    input  logic [PRESET_LEN*NUM_TC-1:0] presetFlat,
    input  logic                         cpuWrEn,
    input  logic [ADDR_LEN-1:0]          cpuWrAddr,
    input  logic [PRESET_LEN-1:0]        cpuWrData,
    output logic                         tcPresetEn,
    output logic [ADDR_LEN-1:0]          tcAddr,
    output logic [PRESET_LEN-1:0]        presetIn,
    output logic [NUM_TC-1:0]            tcDone,
    output logic                         busy,
    output logic                         scanDone,
    output logic                         overrun
);

    localparam logic [0:0]          c_IDLE     = 1'b0;
    localparam logic [0:0]          c_SCAN     = 1'b1;
    localparam logic [ADDR_LEN-1:0] c_LAST_IDX = ADDR_LEN'(NUM_TC - 1);

    logic [0:0]          r_state;
    logic [0:0]          w_stateNext;
    logic [ADDR_LEN-1:0] r_idx;
    logic [ADDR_LEN-1:0] w_idxNext;
    logic                r_pending;
    logic                w_pendingNext;
    logic                r_scanDone;
    logic                w_scanDoneNext;
    logic                r_overrun;
    logic                w_overrunNext;
    logic                w_scanning;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_idx      <= '0;
            r_pending  <= 1'b0;
            r_scanDone <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_idx      <= w_idxNext;
            r_pending  <= w_pendingNext;
            r_scanDone <= w_scanDoneNext;
            r_overrun  <= w_overrunNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_idxNext      = r_idx;
        w_pendingNext  = r_pending;
        w_scanDoneNext = 1'b0;
        w_overrunNext  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (tick) begin
                    w_stateNext = c_SCAN;
                    w_idxNext   = '0;
                end
            end
            c_SCAN: begin
                if (r_idx == c_LAST_IDX) begin
                    // A tick on the final slot is treated as pending, not lost
                    w_scanDoneNext = 1'b1;
                    w_idxNext      = '0;
                    if (r_pending || tick) begin
                        w_stateNext   = c_SCAN;
                        w_pendingNext = r_pending && tick;
                    end else begin
                        w_stateNext   = c_IDLE;
                    end
                end else begin
                    w_idxNext = r_idx + 1'b1;
                    if (tick) begin
                        if (r_pending) w_overrunNext = 1'b1;
                        else           w_pendingNext = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext   = c_IDLE;
                w_idxNext     = '0;
                w_pendingNext = 1'b0;
            end
        endcase
    end

    assign w_scanning = (r_state == c_SCAN);
    assign busy       = w_scanning;
    assign scanDone   = r_scanDone;
    assign overrun    = r_overrun;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tcPresetEn <= 1'b0;
            tcAddr     <= '0;
            presetIn   <= '0;
        end else begin
            tcPresetEn <= cpuWrEn;
            if (cpuWrEn) begin
                tcAddr   <= cpuWrAddr;
                presetIn <= cpuWrData;
            end
        end
    end

    for (genvar k = 0; k < NUM_TC; k++) begin : g_ch
        logic [PRESET_LEN-1:0] r_acc;
        logic [PRESET_LEN-1:0] w_preset;
        logic [PRESET_LEN-1:0] w_accInc;
        logic                  r_done;
        logic                  w_sel;
        logic                  w_clr;

        assign w_preset  = presetFlat[PRESET_LEN*k +: PRESET_LEN];
        assign w_accInc  = r_acc + 1'b1;
        assign w_sel     = w_scanning && (r_idx == ADDR_LEN'(k));
        assign w_clr     = cpuWrEn && (cpuWrAddr == ADDR_LEN'(k));
        assign tcDone[k] = r_done;

        // CPU clear outranks the scan update on the same slot
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_acc  <= '0;
                r_done <= 1'b0;
            end else if (w_clr) begin
                r_acc  <= '0;
                r_done <= 1'b0;
            end else if (w_sel) begin
                if (!tcEnable[k]) begin
                    r_acc  <= '0;
                    r_done <= 1'b0;
                end else if (r_acc >= w_preset) begin
                    r_done <= 1'b1;
                end else begin
                    r_acc  <= w_accInc;
                    r_done <= (w_accInc == w_preset);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tc_scan_ctrl.sv
// ============================================================================
// Module      : tb_tc_scan_ctrl
// Description : Self-checking bench for tc_scan_ctrl with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tc_scan_ctrl;

    localparam int N  = 16;
    localparam int PL = 8;
    localparam int AL = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            tick = 1'b0;
    logic [N-1:0]    tcEnable = '0;
    logic [PL*N-1:0] presetFlat;
    logic            cpuWrEn = 1'b0;
    logic [AL-1:0]   cpuWrAddr = '0;
    logic [PL-1:0]   cpuWrData = '0;
    logic            tcPresetEn;
    logic [AL-1:0]   tcAddr;
    logic [PL-1:0]   presetIn;
    logic [N-1:0]    tcDone;
    logic            busy;
    logic            scanDone;
    logic            overrun;

    logic [PL-1:0]   preset [N];

    int nChecks = 0;
    int nFail   = 0;
    int busyCnt, sdCnt, ovCnt;

    tc_scan_ctrl #(.NUM_TC(N), .PRESET_LEN(PL), .ADDR_LEN(AL)) dut (
        .clk(clk), .reset(reset), .tick(tick), .tcEnable(tcEnable),
        .presetFlat(presetFlat), .cpuWrEn(cpuWrEn), .cpuWrAddr(cpuWrAddr),
        .cpuWrData(cpuWrData), .tcPresetEn(tcPresetEn), .tcAddr(tcAddr),
        .presetIn(presetIn), .tcDone(tcDone), .busy(busy),
        .scanDone(scanDone), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        presetFlat = '0;
        for (int k = 0; k < N; k++) presetFlat[PL*k +: PL] = preset[k];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: scan position -1 means idle, else the channel about to be served
    int mPos = -1;
    bit mPend = 0;
    int mAcc [N];
    bit mDone [N];
    bit mSd = 0, mOv = 0, mPe = 0;
    int mAddr = 0, mData = 0;

    always @(posedge clk) begin
        int k;
        if (!reset) begin
            mPos = -1; mPend = 0; mSd = 0; mOv = 0; mPe = 0; mAddr = 0; mData = 0;
            for (int j = 0; j < N; j++) begin mAcc[j] = 0; mDone[j] = 0; end
        end else begin
            mSd = 0; mOv = 0;
            if (mPos >= 0) begin
                k = mPos;
                if (!tcEnable[k]) begin
                    mAcc[k] = 0; mDone[k] = 0;
                end else begin
                    if (mAcc[k] < int'(preset[k])) mAcc[k]++;
                    mDone[k] = (mAcc[k] >= int'(preset[k]));
                end
            end
            if (cpuWrEn && int'(cpuWrAddr) < N) begin
                mAcc[cpuWrAddr] = 0; mDone[cpuWrAddr] = 0;
            end
            mPe = cpuWrEn;
            if (cpuWrEn) begin mAddr = cpuWrAddr; mData = cpuWrData; end
            if (mPos < 0) begin
                if (tick) mPos = 0;
            end else if (mPos == N - 1) begin
                mSd = 1;
                if (mPend || tick) begin mPos = 0; mPend = mPend && tick; end
                else mPos = -1;
            end else begin
                if (tick) begin
                    if (mPend) mOv = 1;
                    else mPend = 1;
                end
                mPos++;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] expDone;
        for (int j = 0; j < N; j++) expDone[j] = mDone[j];
        chk("cmp_busy", busy, mPos >= 0);
        chk("cmp_scanDone", scanDone, mSd);
        chk("cmp_overrun", overrun, mOv);
        chk("cmp_tcDone", tcDone, expDone);
        chk("cmp_tcPresetEn", tcPresetEn, mPe);
        chk("cmp_tcAddr", tcAddr, mAddr[AL-1:0]);
        chk("cmp_presetIn", presetIn, mData[PL-1:0]);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clrCnt();
        busyCnt = 0; sdCnt = 0; ovCnt = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            if (busy) busyCnt++;
            if (scanDone) sdCnt++;
            if (overrun) ovCnt++;
            step();
        end
    endtask

    task automatic oneScan();
        tick = 1'b1;
        step();
        tick = 1'b0;
        clrCnt();
        watch(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) preset[k] = 8'd200;
        preset[0] = 8'd1; preset[2] = 8'd5; preset[3] = 8'd3;
        preset[5] = 8'd0; preset[7] = 8'd0; preset[9] = 8'd0;
        tcEnable = 16'h00AD;

        reset = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_tcDone", tcDone, '0);
        chk("rst_presetEn", tcPresetEn, 1'b0);
        chk("rst_tcAddr", tcAddr, '0);
        chk("rst_presetIn", presetIn, '0);
        reset = 1'b1;
        step();

        // Single scan: 16 busy cycles, one scanDone
        oneScan();
        chk("scan1_busyLen", busyCnt, 16);
        chk("scan1_sdCnt", sdCnt, 1);
        chk("scan1_ovCnt", ovCnt, 0);
        chk("scan1_done7_preset0", tcDone[7], 1'b1);
        chk("scan1_done5_preset0", tcDone[5], 1'b1);
        chk("scan1_done3", tcDone[3], 1'b0);

        oneScan();
        chk("scan2_done3", tcDone[3], 1'b0);
        oneScan();
        chk("scan3_done3", tcDone[3], 1'b1);
        chk("scan3_model_acc3", mAcc[3], 3);
        oneScan();
        chk("scan4_done3", tcDone[3], 1'b1);
        chk("scan4_model_acc3", mAcc[3], 3);

        // Ticks at scan cycles 5 and 9: back-to-back rescan plus one overrun
        tick = 1'b1;
        step();
        tick = 1'b0;
        clrCnt();
        for (int i = 0; i < 40; i++) begin
            tick = (i == 5 || i == 9);
            if (busy) busyCnt++;
            if (scanDone) sdCnt++;
            if (overrun) ovCnt++;
            step();
        end
        tick = 1'b0;
        chk("pend_busyLen", busyCnt, 32);
        chk("pend_sdCnt", sdCnt, 2);
        chk("pend_ovCnt", ovCnt, 1);

        // CPU write to the channel currently being scanned
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (7) step();
        chk("wr7_done_before", tcDone[7], 1'b1);
        cpuWrEn = 1'b1; cpuWrAddr = 4'd7; cpuWrData = 8'h20;
        step();
        cpuWrEn = 1'b0;
        chk("wr7_presetEn", tcPresetEn, 1'b1);
        chk("wr7_tcAddr", tcAddr, 4'd7);
        chk("wr7_presetIn", presetIn, 8'h20);
        chk("wr7_done_after", tcDone[7], 1'b0);
        chk("wr7_model_acc7", mAcc[7], 0);
        repeat (12) step();

        // CPU write while idle, then outputs hold
        cpuWrEn = 1'b1; cpuWrAddr = 4'd3; cpuWrData = 8'h09;
        step();
        cpuWrEn = 1'b0;
        chk("wr3_done", tcDone[3], 1'b0);
        chk("wr3_tcAddr", tcAddr, 4'd3);
        step();
        chk("wr3_presetEn_low", tcPresetEn, 1'b0);
        chk("wr3_presetIn_hold", presetIn, 8'h09);

        // Disable a done channel; enable a preset-0 channel
        chk("dis2_done_before", tcDone[2], 1'b1);
        tcEnable[2] = 1'b0;
        tcEnable[9] = 1'b1;
        oneScan();
        chk("dis2_done_after", tcDone[2], 1'b0);
        chk("dis2_model_acc2", mAcc[2], 0);
        chk("en9_done", tcDone[9], 1'b1);

        // Reset mid-scan, colliding with tick and CPU write
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (8) step();
        reset = 1'b0; tick = 1'b1;
        cpuWrEn = 1'b1; cpuWrAddr = 4'd4; cpuWrData = 8'h55;
        step();
        reset = 1'b1; tick = 1'b0; cpuWrEn = 1'b0;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_tcDone", tcDone, '0);
        chk("mid_rst_scanDone", scanDone, 1'b0);
        chk("mid_rst_overrun", overrun, 1'b0);
        chk("mid_rst_presetEn", tcPresetEn, 1'b0);
        chk("mid_rst_tcAddr", tcAddr, '0);
        chk("mid_rst_presetIn", presetIn, '0);
        clrCnt();
        watch(10);
        chk("post_rst_sdCnt", sdCnt, 0);
        chk("post_rst_busyCnt", busyCnt, 0);
        oneScan();
        chk("restart_busyLen", busyCnt, 16);
        chk("restart_sdCnt", sdCnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

`default_nettype wire
